// File: rtl/memory_arbiter.sv
// memory_arbiter: data-priority arbiter of instruction fetch and data access onto a single-port RAM.
// A starvation counter forces instruction grants; a watchdog aborts hung RAM transactions.
module memory_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              ihit,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dhit,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramready,
  input  logic              ramerr,
  output logic              err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT, HIT} state_t;
  state_t state, next;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] store_q;
  logic wr_q, data_q, pick_d, grant, abort, done;
  logic [15:0] wait_cnt;
  logic [SW-1:0] starve;
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= next;
  // RAM-side outputs come only from state and latched request, so reset drops them at once
  always_comb begin
    pick_d = (dREN | dWEN) & ~(iREN & (starve == SW'(STARVE_LIMIT)));
    grant = state == DGRANT || state == IGRANT;
    abort = grant & (ramerr | (~ramready & (wait_cnt == 16'(TIMEOUT - 1))));
    done = grant & ramready & ~ramerr;
    next = state == HIT ? IDLE
         : state == IDLE ? (pick_d ? DGRANT : iREN ? IGRANT : IDLE)
         : abort ? IDLE : done ? HIT : state;
    ramREN = state == IGRANT || (state == DGRANT && !wr_q);
    ramWEN = state == DGRANT && wr_q;
    ramaddr = grant ? addr_q : '0;
    ramstore = ramWEN ? store_q : '0;
    ihit = state == HIT && !data_q;
    dhit = state == HIT && data_q;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      addr_q <= '0;
      store_q <= '0;
      wr_q <= 1'b0;
      data_q <= 1'b0;
      wait_cnt <= '0;
      starve <= '0;
      iload <= '0;
      dload <= '0;
      err <= 1'b0;
    end else begin
      wait_cnt <= grant ? wait_cnt + 16'd1 : '0;
      err <= err | abort;
      if (state == IDLE && pick_d) begin
        addr_q <= daddr;
        store_q <= dstore;
        wr_q <= dWEN;
        data_q <= 1'b1;
        starve <= iREN ? starve + SW'(1) : '0;
      end else if (state == IDLE && iREN) begin
        addr_q <= iaddr;
        wr_q <= 1'b0;
        data_q <= 1'b0;
        starve <= '0;
      end
      if (done && !wr_q && data_q) dload <= ramload;
      if (done && !data_q) iload <= ramload;
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed and random stimulus checked every cycle against a transaction-level model.
module tb_memory_arbiter;
  localparam int TIMEOUT = 255, LIMIT = 4;
  logic CLK = 0, RST = 1;
  logic iREN = 0, dREN = 0, dWEN = 0, ramready = 0, ramerr = 0;
  logic [31:0] iaddr = 0, daddr = 0, dstore = 0, ramload = 0;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic ihit, dhit, ramREN, ramWEN, err;
  memory_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .ramerr(ramerr), .err(err));
  always #5 CLK = ~CLK;
  int tests = 0, fails = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask
  // model: one in-flight transaction record, a pending hit, and the running starve count
  bit tv = 0, t_data = 0, t_wr = 0, m_err = 0;
  logic [31:0] t_addr = 0, t_store = 0, m_iload = 0, m_dload = 0;
  int t_waited = 0, hit_kind = 0, starve = 0;
  int grants[$];
  task automatic model_edge();
    if (RST) begin
      tv = 0; hit_kind = 0; starve = 0; m_iload = 0; m_dload = 0; m_err = 0;
    end else if (hit_kind != 0) hit_kind = 0;
    else if (tv) begin
      t_waited++;
      if (ramerr || (!ramready && t_waited == TIMEOUT)) begin
        m_err = 1; tv = 0;
      end else if (ramready) begin
        if (!t_wr) begin
          if (t_data) m_dload = ramload;
          else m_iload = ramload;
        end
        hit_kind = t_data ? 2 : 1;
        tv = 0;
      end
    end else if ((dREN || dWEN) && !(iREN && starve == LIMIT)) begin
      tv = 1; t_data = 1; t_wr = dWEN; t_addr = daddr; t_store = dstore; t_waited = 0;
      starve = iREN ? starve + 1 : 0;
      grants.push_back(1);
    end else if (iREN) begin
      tv = 1; t_data = 0; t_wr = 0; t_addr = iaddr; t_waited = 0; starve = 0;
      grants.push_back(0);
    end
  endtask
  always @(posedge CLK or posedge RST) model_edge();
  always @(negedge CLK) begin
    chk("ramREN", ramREN, tv && !(t_data && t_wr));
    chk("ramWEN", ramWEN, tv && t_data && t_wr);
    chk("ramaddr", ramaddr, tv ? t_addr : 32'd0);
    chk("ramstore", ramstore, (tv && t_data && t_wr) ? t_store : 32'd0);
    chk("ihit", ihit, hit_kind == 1);
    chk("dhit", dhit, hit_kind == 2);
    chk("iload", iload, m_iload);
    chk("dload", dload, m_dload);
    chk("err", err, m_err);
  end
  int lat = 0, ren_cnt, wen_cnt, ihit_cnt, dhit_cnt, ihit_at, dhit_at, cyc_no = 0, base;
  bit err_cfg = 0, rnd = 0, hold_d = 0;
  logic [31:0] ram_data = 0, last_addr, last_store, got_iload, got_dload, dl0;
  task automatic cyc();
    int k;
    @(negedge CLK);
    if (hit_kind == 1) iREN = 0;
    if (hit_kind == 2 && !hold_d) begin dREN = 0; dWEN = 0; end
    if (rnd) begin
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ram_data = $urandom;
      if (!iREN && $urandom_range(2) == 0) iREN = 1;
      if (!dREN && !dWEN && $urandom_range(2) == 0) begin
        k = $urandom_range(3);
        dREN = k != 2;
        dWEN = k >= 2;
      end
    end
    ramload = ram_data;
    ramready = tv && (rnd ? ($urandom_range(1) == 0) : (t_waited >= lat));
    ramerr = tv && (rnd ? ($urandom_range(149) == 0) : (err_cfg && t_waited >= lat));
    if (rnd && !tv) ramready = $urandom_range(7) == 0;
  endtask
  task automatic clear();
    ren_cnt = 0; wen_cnt = 0; ihit_cnt = 0; dhit_cnt = 0; ihit_at = -1; dhit_at = -1;
    last_addr = 0; last_store = 0; got_iload = 0; got_dload = 0;
  endtask
  task automatic watch(input int n);
    for (int c = 0; c < n; c++) begin
      cyc();
      if (ramREN) begin ren_cnt++; last_addr = ramaddr; end
      if (ramWEN) begin wen_cnt++; last_addr = ramaddr; last_store = ramstore; end
      if (ihit) begin ihit_cnt++; ihit_at = cyc_no; got_iload = iload; end
      if (dhit) begin dhit_cnt++; dhit_at = cyc_no; got_dload = dload; end
      cyc_no++;
    end
  endtask
  task automatic do_reset();
    #2 RST = 1;
    #1;
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_dhit", dhit, 0);
    chk("rst_err", err, 0);
    cyc();
    RST = 0;
  endtask
  initial begin
    repeat (2) @(negedge CLK);
    chk("reset_iload", iload, 0);
    chk("reset_ramaddr", ramaddr, 0);
    chk("reset_hits", {ihit, dhit}, 0);
    RST = 0;
    // instruction only, two wait cycles
    clear(); iREN = 1; iaddr = 32'h40; lat = 2; ram_data = 32'h8C220004;
    watch(10);
    chk("t1_ren_cycles", ren_cnt, 3);
    chk("t1_addr", last_addr, 32'h40);
    chk("t1_ihit", ihit_cnt, 1);
    chk("t1_dhit", dhit_cnt, 0);
    chk("t1_iload", got_iload, 32'h8C220004);
    // simultaneous: data first, instruction three cycles later
    clear(); base = grants.size();
    iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h100; lat = 0; ram_data = 32'hDEADBEEF;
    watch(12);
    chk("t2_dhit", dhit_cnt, 1);
    chk("t2_ihit", ihit_cnt, 1);
    chk("t2_dload", got_dload, 32'hDEADBEEF);
    chk("t2_spacing", ihit_at - dhit_at, 3);
    chk("t2_order", {grants[base], grants[base+1]}, 64'h0000000100000000);
    // write leaves dload alone
    clear(); dWEN = 1; daddr = 32'h200; dstore = 32'h12345678; lat = 1; ram_data = 32'hAAAA5555;
    watch(10);
    chk("t3_wen_cycles", wen_cnt, 2);
    chk("t3_ren_cycles", ren_cnt, 0);
    chk("t3_store", last_store, 32'h12345678);
    chk("t3_addr", last_addr, 32'h200);
    chk("t3_dhit", dhit_cnt, 1);
    chk("t3_dload", dload, 32'hDEADBEEF);
    // starvation: four data grants, then the instruction
    clear(); base = grants.size();
    iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h180; hold_d = 1; lat = 0;
    watch(30);
    chk("t4_len", grants.size() >= base + 5, 1);
    for (int g = 0; g < 4; g++) chk("t4_data_grant", grants[base+g], 1);
    chk("t4_instr_grant", grants[base+4], 0);
    chk("t4_ihit", ihit_cnt, 1);
    hold_d = 0; dREN = 0;
    watch(6);
    // ramerr together with ramready
    clear(); dl0 = dload; err_cfg = 1; lat = 0; dREN = 1; daddr = 32'h300;
    watch(1); dREN = 0;
    watch(5);
    chk("t5_dhit", dhit_cnt, 0);
    chk("t5_err", err, 1);
    chk("t5_dload", dload, dl0);
    err_cfg = 0;
    // watchdog timeout
    do_reset();
    clear(); lat = 1 << 30; iREN = 1; iaddr = 32'h500;
    watch(1); iREN = 0;
    watch(299);
    chk("t6_ren_cycles", ren_cnt, TIMEOUT);
    chk("t6_ihit", ihit_cnt, 0);
    chk("t6_err", err, 1);
    // reset in the middle of a data grant
    clear(); dREN = 1; daddr = 32'h400;
    watch(1); dREN = 0;
    watch(2);
    chk("t7_pre_ren", ramREN, 1);
    do_reset();
    clear(); watch(3);
    chk("t7_err", err, 0);
    chk("t7_ren", ren_cnt, 0);
    // random traffic with occasional resets
    rnd = 1;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if ($urandom_range(499) == 0) do_reset();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
